conv1d_mac_ctrl: RTL
====================

Name: conv1d_mac_ctrl

Overview:
Sequencer for the combinational conv1d MAC (psum_out = weight*feature + psum_in). For each output point it walks the kernel taps and issues reads to the feature and weight buffers. It feeds the MAC and closes the accumulation loop through an internal psum register, then emits each finished sum on a valid/ready stream. It sits between the conv1d line/weight buffers and the output writer, one instance per MAC.

Parameters:
WIDTH_DATA, 8, operand width; matches `WIDTH_DATA in define.v; psum/result width is 2*WIDTH_DATA
ADDR_W, 8, feature-buffer address width
KADDR_W, 4, weight-buffer address width; max kernel length is 2^KADDR_W-1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; sampled only in IDLE
cfg_kernel_len  in  KADDR_W  taps per output (K)
cfg_out_len  in  ADDR_W  number of outputs (N)
cfg_stride  in  ADDR_W  feature address step between outputs (S)
fm_rd_en  out  1  feature buffer read enable
fm_addr  out  ADDR_W  feature read address
fm_rdata  in  WIDTH_DATA  feature data, 1-cycle read latency
wt_rd_en  out  1  weight buffer read enable
wt_addr  out  KADDR_W  weight read address
wt_rdata  in  WIDTH_DATA  weight data, 1-cycle read latency
mac_weight  out  WIDTH_DATA  to MAC weight
mac_feature  out  WIDTH_DATA  to MAC feature
mac_psum_in  out  2*WIDTH_DATA  to MAC psum_in
mac_psum_out  in  2*WIDTH_DATA  from MAC psum_out
out_data  out  2*WIDTH_DATA  finished sum
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, and tap/output counters, acc, rd_vld and all registered outputs go to 0. This applies mid-run as well: the transfer is abandoned, no done pulse, and no output is left pending.
- Config is latched on start in IDLE. start is ignored outside IDLE.
- Degenerate config: K=0 or N=0 -> state goes to FIN, done pulses one cycle after start, and no reads or outputs occur.
- States: IDLE -> RUN (start and K,N nonzero) -> DRAIN (last tap issued) -> OUT (last tap accumulated) -> RUN (handshake and more outputs) | FIN (handshake and last output) -> IDLE. FIN lasts one cycle and drives done=1.
- RUN: one tap is issued per cycle, k=0..K-1.
  - fm_addr = o*S + k, truncated to ADDR_W (wraps).
  - wt_addr = k.
  - Both rd_en are high only in RUN.
- rd_vld and first flags are the issue flags delayed 1 cycle, aligned with rdata.
- MAC inputs: mac_weight=wt_rdata and mac_feature=fm_rdata. mac_psum_in = 0 when the first tap's data is present, else acc. When rd_vld=0, mac_weight and mac_feature are 0.
- Accumulation: acc <= mac_psum_out on every rd_vld cycle.
  - Arithmetic is unsigned, modulo 2^(2*WIDTH_DATA), with no saturation.
- Timing: with start sampled at edge E0, reads are issued in the K cycles after E0. out_valid rises after edge E0+K+1. Each subsequent output's out_valid rises K+1 cycles after the previous handshake edge. There is no overlap between outputs.
- OUT: out_valid=1 and out_data=acc, held stable until out_valid&out_ready. The handshake edge deasserts out_valid unless the next output is already ready. Per the timing above this never happens, so out_valid always drops for at least K cycles.
- out_data holds its last value when out_valid=0.
- Output o counter wraps only through N; the address computation uses an incrementing base (base += S), not a multiplier.

Test Plan:
- K=1, N=4, S=1, all features 13, weight 6 -> four outputs of 78. out_valid first rises 2 cycles after start; done pulses once after the 4th handshake.
- K=3, weights {1,2,3}, features {1..8}, S=1, N=4, out_ready=1 -> outputs 14, 20, 26, 32 in order, each K+1=4 cycles after the previous handshake.
- Same data with S=2, N=3 -> outputs 14, 26, 38. fm_addr sequence is 0,1,2 / 2,3,4 / 4,5,6.
- Backpressure: K=3 case with out_ready held low 5 cycles on output 0 -> out_valid=1 and out_data=14 stable throughout, no further reads issued, and result 1 is still 20.
- Overflow: WIDTH_DATA=8, K=2, weights and features 255 -> out_data = 130050 mod 65536 = 64514.
- Reset and degenerate config:
  - rst_n=0 for 1 cycle mid-RUN -> next cycle busy=0, out_valid=0, done=0. A new start then reproduces the 14,20,26,32 result.
  - K=0 -> done pulses 1 cycle after start, with no fm_rd_en or out_valid.

Source files
------------

// File: rtl/conv1d_mac_ctrl.sv
// Tap/output sequencer for a combinational conv1d MAC: issues feature/weight
// reads, closes the psum loop through acc_q, and streams finished sums out.
module conv1d_mac_ctrl #(
  parameter int WIDTH_DATA = 8,
  parameter int ADDR_W     = 8,
  parameter int KADDR_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KADDR_W-1:0]      cfg_kernel_len,
  input  logic [ADDR_W-1:0]       cfg_out_len,
  input  logic [ADDR_W-1:0]       cfg_stride,
  output logic                    fm_rd_en,
  output logic [ADDR_W-1:0]       fm_addr,
  input  logic [WIDTH_DATA-1:0]   fm_rdata,
  output logic                    wt_rd_en,
  output logic [KADDR_W-1:0]      wt_addr,
  input  logic [WIDTH_DATA-1:0]   wt_rdata,
  output logic [WIDTH_DATA-1:0]   mac_weight,
  output logic [WIDTH_DATA-1:0]   mac_feature,
  output logic [2*WIDTH_DATA-1:0] mac_psum_in,
  input  logic [2*WIDTH_DATA-1:0] mac_psum_out,
  output logic [2*WIDTH_DATA-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = 2 * WIDTH_DATA;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, FIN} state_t;

  state_t              state_q, state_d;
  logic [KADDR_W-1:0]  k_q, k_d, cfg_k_q, cfg_k_d;
  logic [ADDR_W-1:0]   o_q, o_d, base_q, base_d;
  logic [ADDR_W-1:0]   cfg_n_q, cfg_n_d, cfg_s_q, cfg_s_d;
  logic [ADDR_W-1:0]   fm_addr_q, fm_addr_d;
  logic                rd_en_q, rd_en_d, rd_vld_q, rd_vld_d, first_q, first_d;
  logic                out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic [PW-1:0]       acc_q, acc_d, out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    o_d         = o_q;
    base_d      = base_q;
    cfg_k_d     = cfg_k_q;
    cfg_n_d     = cfg_n_q;
    cfg_s_d     = cfg_s_q;
    fm_addr_d   = fm_addr_q;
    rd_en_d     = rd_en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    // Issue flags delayed one cycle so they line up with the buffer read data.
    rd_vld_d    = rd_en_q;
    first_d     = rd_en_q && (k_q == '0);
    acc_d       = rd_vld_q ? mac_psum_out : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_k_d   = cfg_kernel_len;
          cfg_n_d   = cfg_out_len;
          cfg_s_d   = cfg_stride;
          o_d       = '0;
          base_d    = '0;
          k_d       = '0;
          fm_addr_d = '0;
          if (cfg_kernel_len == '0 || cfg_out_len == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            rd_en_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (k_q == cfg_k_q - KADDR_W'(1)) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
          k_d     = '0;
        end else begin
          // fm_addr tracks base + k by stepping alongside the tap counter.
          k_d       = k_q + KADDR_W'(1);
          fm_addr_d = fm_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        out_data_d  = mac_psum_out;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (o_q == cfg_n_q - ADDR_W'(1)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = RUN;
            o_d       = o_q + ADDR_W'(1);
            base_d    = base_q + cfg_s_q;
            fm_addr_d = base_q + cfg_s_q;
            k_d       = '0;
            rd_en_d   = 1'b1;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      o_q         <= '0;
      base_q      <= '0;
      cfg_k_q     <= '0;
      cfg_n_q     <= '0;
      cfg_s_q     <= '0;
      fm_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      o_q         <= o_d;
      base_q      <= base_d;
      cfg_k_q     <= cfg_k_d;
      cfg_n_q     <= cfg_n_d;
      cfg_s_q     <= cfg_s_d;
      fm_addr_q   <= fm_addr_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_vld_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fm_rd_en    = rd_en_q;
  assign wt_rd_en    = rd_en_q;
  assign fm_addr     = fm_addr_q;
  assign wt_addr     = k_q;
  assign mac_weight  = rd_vld_q ? wt_rdata : '0;
  assign mac_feature = rd_vld_q ? fm_rdata : '0;
  assign mac_psum_in = first_q ? '0 : acc_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
